// File: rtl/uvma_cvmcu_io_pad_drvr.sv
// uvma_cvmcu_io_pad_drvr
// Board-side pad driver for the cvmcu_io interface. It accepts queued pad
// commands into a small FIFO and applies them one at a time through an
// IDLE/APPLY/HOLD sequencer. The sequencer drives the per-pad io_in lines back
// into the MCU and flags contention when the MCU enables a pad this block is
// driving.
// Optional feature: define CVMCU_IO_PAD_DRVR_LOOPBACK_EN to make undriven pads
// with an active output enable present io_out_i one registered cycle late.
module uvma_cvmcu_io_pad_drvr #(
    parameter int   NUM_PADS   = 48,
    parameter int   PAD_IDX_W  = 6,
    parameter int   HOLD_W     = 8,
    parameter int   FIFO_DEPTH = 4,
    parameter logic IDLE_VALUE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [PAD_IDX_W-1:0] cmd_pad_i,
    input  logic                 cmd_value_i,
    input  logic [HOLD_W-1:0]    cmd_hold_i,
    input  logic                 cmd_release_i,
    input  logic [NUM_PADS-1:0]  io_out_i,
    input  logic [NUM_PADS-1:0]  io_oe_i,
    output logic [NUM_PADS-1:0]  io_in_o,
    output logic                 busy_o,
    output logic                 contention_o,
    output logic [PAD_IDX_W-1:0] contention_pad_o,
    output logic                 bad_idx_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [PAD_IDX_W-1:0] pad;
        logic                 value;
        logic [HOLD_W-1:0]    hold;
        logic                 rel;
    } cmd_t;

    cmd_t                 fifo_q [FIFO_DEPTH];
    cmd_t                 fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ready_q, ready_d;
    state_e               state_q, state_d;
    cmd_t                 cmd_q, cmd_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                 busy_q, busy_d;
    logic [NUM_PADS-1:0]  io_in_q, io_in_d;
    logic [NUM_PADS-1:0]  driven_q, driven_d;
    logic                 bad_idx_q, bad_idx_d;
    logic                 c_any_q, c_any_d;
    logic                 contention_q, contention_d;
    logic [PAD_IDX_W-1:0] contention_pad_q, contention_pad_d;

    logic                 push_s;
    logic                 pop_s;
    logic [NUM_PADS-1:0]  c_s;
    logic [PAD_IDX_W-1:0] c_low_s;

    // Command FIFO: push on handshake, pop when the sequencer is idle; ready comes from registered count.
    always_comb begin
        push_s   = cmd_valid_i && ready_q;
        pop_s    = (state_q == ST_IDLE) && (count_q != {CNT_W{1'b0}});
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            fifo_d[wr_ptr_q].pad   = cmd_pad_i;
            fifo_d[wr_ptr_q].value = cmd_value_i;
            fifo_d[wr_ptr_q].hold  = cmd_hold_i;
            fifo_d[wr_ptr_q].rel   = cmd_release_i;
            wr_ptr_d               = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    end

    // Sequencer next state: pop/latch in IDLE, load the hold counter in APPLY, count down in HOLD.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_APPLY;
                    cmd_d   = fifo_q[rd_ptr_q];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                state_d = ST_HOLD;
                // A hold of zero behaves like a hold of one.
                if (cmd_q.hold == {HOLD_W{1'b0}}) begin
                    hold_cnt_d = {HOLD_W{1'b0}};
                end else begin
                    hold_cnt_d = cmd_q.hold - HOLD_W'(1'b1);
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == {HOLD_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (count_d != {CNT_W{1'b0}}) || (state_d != ST_IDLE);
    end

    // Pad image: optional loopback on undriven pads, then the APPLY-edge update for the latched command.
    always_comb begin
        io_in_d   = io_in_q;
        driven_d  = driven_q;
        bad_idx_d = bad_idx_q;
`ifdef CVMCU_IO_PAD_DRVR_LOOPBACK_EN
        for (int i = 0; i < NUM_PADS; i++) begin
            if (!driven_q[i]) begin
                io_in_d[i] = io_oe_i[i] ? io_out_i[i] : IDLE_VALUE;
            end else begin
                io_in_d[i] = io_in_q[i];
            end
        end
`endif
        if (state_q == ST_APPLY) begin
            if (32'(cmd_q.pad) >= NUM_PADS) begin
                // Out-of-range target: keep normal timing but touch no pad.
                bad_idx_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_PADS; i++) begin
                    if (cmd_q.pad == PAD_IDX_W'(i)) begin
                        io_in_d[i]  = cmd_q.rel ? IDLE_VALUE : cmd_q.value;
                        driven_d[i] = !cmd_q.rel;
                    end else begin
                        driven_d[i] = driven_d[i];
                    end
                end
            end
        end else begin
            bad_idx_d = bad_idx_q;
        end
    end

    // Contention detect: pulse on the rising edge of any(driven & oe), capturing the lowest index.
    always_comb begin
        c_s     = driven_q & io_oe_i;
        c_any_d = |c_s;
        c_low_s = {PAD_IDX_W{1'b0}};
        for (int i = NUM_PADS - 1; i >= 0; i--) begin
            if (c_s[i]) begin
                c_low_s = PAD_IDX_W'(i);
            end else begin
                c_low_s = c_low_s;
            end
        end
        contention_d = c_any_d && !c_any_q;
        if (contention_d) begin
            contention_pad_d = c_low_s;
        end else begin
            contention_pad_d = contention_pad_q;
        end
    end

    // State register with synchronous reset; reset discards queued and in-flight commands.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_q           <= '{default: {$bits(cmd_t){1'b0}}};
            wr_ptr_q         <= {PTR_W{1'b0}};
            rd_ptr_q         <= {PTR_W{1'b0}};
            count_q          <= {CNT_W{1'b0}};
            ready_q          <= 1'b1;
            state_q          <= ST_IDLE;
            cmd_q            <= {$bits(cmd_t){1'b0}};
            hold_cnt_q       <= {HOLD_W{1'b0}};
            busy_q           <= 1'b0;
            io_in_q          <= {NUM_PADS{IDLE_VALUE}};
            driven_q         <= {NUM_PADS{1'b0}};
            bad_idx_q        <= 1'b0;
            c_any_q          <= 1'b0;
            contention_q     <= 1'b0;
            contention_pad_q <= {PAD_IDX_W{1'b0}};
        end else begin
            fifo_q           <= fifo_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            ready_q          <= ready_d;
            state_q          <= state_d;
            cmd_q            <= cmd_d;
            hold_cnt_q       <= hold_cnt_d;
            busy_q           <= busy_d;
            io_in_q          <= io_in_d;
            driven_q         <= driven_d;
            bad_idx_q        <= bad_idx_d;
            c_any_q          <= c_any_d;
            contention_q     <= contention_d;
            contention_pad_q <= contention_pad_d;
        end
    end

`ifndef CVMCU_IO_PAD_DRVR_LOOPBACK_EN
    logic unused_io_out_s;
    assign unused_io_out_s = ^io_out_i;
`endif

    assign cmd_ready_o      = ready_q;
    assign busy_o           = busy_q;
    assign io_in_o          = io_in_q;
    assign contention_o     = contention_q;
    assign contention_pad_o = contention_pad_q;
    assign bad_idx_o        = bad_idx_q;

endmodule

// File: tb/tb_uvma_cvmcu_io_pad_drvr.sv
// Testbench for uvma_cvmcu_io_pad_drvr. The reference model tracks the command
// queue and schedules each command by time: a command popped at edge p updates
// its pad at edge p+1 and frees the driver at cycle p+2+max(hold,1).
module tb_uvma_cvmcu_io_pad_drvr;

    localparam int NP = 48;

    typedef struct packed {
        logic [5:0] pad;
        logic       val;
        logic [7:0] hold;
        logic       rel;
    } cmd_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [5:0]    cmd_pad_i;
    logic          cmd_value_i;
    logic [7:0]    cmd_hold_i;
    logic          cmd_release_i;
    logic [NP-1:0] io_out_i;
    logic [NP-1:0] io_oe_i;
    logic [NP-1:0] io_in_o;
    logic          busy_o;
    logic          contention_o;
    logic [5:0]    contention_pad_o;
    logic          bad_idx_o;

    uvma_cvmcu_io_pad_drvr dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_pad_i        (cmd_pad_i),
        .cmd_value_i      (cmd_value_i),
        .cmd_hold_i       (cmd_hold_i),
        .cmd_release_i    (cmd_release_i),
        .io_out_i         (io_out_i),
        .io_oe_i          (io_oe_i),
        .io_in_o          (io_in_o),
        .busy_o           (busy_o),
        .contention_o     (contention_o),
        .contention_pad_o (contention_pad_o),
        .bad_idx_o        (bad_idx_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int t           = 0;

    // Reference model state.
    cmd_t          mq[$];
    cmd_t          m_cur;
    int            m_apply_edge = -1;
    int            m_idle_from  = 0;
    logic [NP-1:0] m_io;
    logic [NP-1:0] m_drv;
    logic          m_prev_any;
    logic          m_cont;
    logic          m_bad;
    logic [5:0]    m_cpad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [5:0] lowest(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) begin
            if (v[i]) return 6'(i);
        end
        return 6'd0;
    endfunction

    task automatic check_all();
        chk("io_in", 64'(io_in_o), 64'(m_io));
        chk("ready", 64'(cmd_ready_o), 64'(mq.size() < 4));
        chk("busy", 64'(busy_o), 64'((mq.size() != 0) || (t < m_idle_from)));
        chk("contention", 64'(contention_o), 64'(m_cont));
        chk("contention_pad", 64'(contention_pad_o), 64'(m_cpad));
        chk("bad_idx", 64'(bad_idx_o), 64'(m_bad));
    endtask

    // Advance the model across the edge that ends cycle t, using the inputs present now.
    task automatic model_edge();
        logic [NP-1:0] c;
        bit            acc;
        int            h;
        if (reset) begin
            mq.delete();
            m_apply_edge = -1;
            m_idle_from  = t + 1;
            m_io         = '1;
            m_drv        = '0;
            m_prev_any   = 1'b0;
            m_cont       = 1'b0;
            m_bad        = 1'b0;
            m_cpad       = 6'd0;
        end else begin
            acc        = cmd_valid_i && (mq.size() < 4);
            c          = m_drv & io_oe_i;
            m_cont     = (c != '0) && !m_prev_any;
            if (m_cont) m_cpad = lowest(c);
            m_prev_any = (c != '0);
`ifdef CVMCU_IO_PAD_DRVR_LOOPBACK_EN
            for (int i = 0; i < NP; i++) begin
                if (!m_drv[i]) m_io[i] = io_oe_i[i] ? io_out_i[i] : 1'b1;
            end
`endif
            if (t == m_apply_edge) begin
                if (m_cur.pad >= NP) begin
                    m_bad = 1'b1;
                end else if (m_cur.rel) begin
                    m_io[m_cur.pad]  = 1'b1;
                    m_drv[m_cur.pad] = 1'b0;
                end else begin
                    m_io[m_cur.pad]  = m_cur.val;
                    m_drv[m_cur.pad] = 1'b1;
                end
            end
            if ((t >= m_idle_from) && (mq.size() > 0)) begin
                m_cur        = mq.pop_front();
                h            = (m_cur.hold == 8'd0) ? 1 : int'(m_cur.hold);
                m_apply_edge = t + 1;
                m_idle_from  = t + 2 + h;
            end
            if (acc) mq.push_back('{cmd_pad_i, cmd_value_i, cmd_hold_i, cmd_release_i});
        end
    endtask

    task automatic tick();
        check_all();
        model_edge();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic push(input logic [5:0] pad, input logic val, input logic [7:0] hold, input logic rel);
        bit acc = 1'b0;
        cmd_valid_i   = 1'b1;
        cmd_pad_i     = pad;
        cmd_value_i   = val;
        cmd_hold_i    = hold;
        cmd_release_i = rel;
        for (int n = 0; n < 600 && !acc; n++) begin
            acc = (mq.size() < 4);
            tick();
        end
        chk("push_accept_timeout", 64'(acc), 64'd1);
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (((mq.size() != 0) || (t < m_idle_from)) && (n < 700)) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < 700), 64'd1);
    endtask

    initial begin
        int pulses;
        logic [5:0] seen_pad;
        reset         = 1'b1;
        cmd_valid_i   = 1'b0;
        cmd_pad_i     = 6'd0;
        cmd_value_i   = 1'b0;
        cmd_hold_i    = 8'd0;
        cmd_release_i = 1'b0;
        io_out_i      = '0;
        io_oe_i       = '0;

        // Reset: first edge without comparison (DUT still unknown before it).
        model_edge();
        @(posedge clk);
        #1;
        t++;
        tick();
        reset = 1'b0;
        chk("reset_io_in", 64'(io_in_o), 64'hFFFF_FFFF_FFFF);
        chk("reset_ready", 64'(cmd_ready_o), 64'd1);
        chk("reset_busy", 64'(busy_o), 64'd0);

        // Single drive: pad 3 <- 0, hold 4; accepted at edge 0.
        push(6'd3, 1'b0, 8'd4, 1'b0);
        tick();
        chk("single_c2_pad3", 64'(io_in_o[3]), 64'd1);
        tick();
        chk("single_c3_pad3", 64'(io_in_o[3]), 64'd0);
        chk("single_c3_others", 64'(io_in_o | (48'd1 << 3)), 64'hFFFF_FFFF_FFFF);
        tick();
        tick();
        tick();
        chk("single_c6_busy", 64'(busy_o), 64'd1);
        tick();
        chk("single_c7_busy", 64'(busy_o), 64'd0);

        // FIFO full: long first hold, then enough commands to fill and block.
        push(6'd10, 1'b0, 8'd255, 1'b0);
        push(6'd11, 1'b0, 8'd1, 1'b0);
        push(6'd12, 1'b1, 8'd2, 1'b0);
        push(6'd13, 1'b0, 8'd0, 1'b0);
        push(6'd14, 1'b0, 8'd1, 1'b0);
        chk("fifo_full_ready", 64'(cmd_ready_o), 64'd0);
        push(6'd15, 1'b0, 8'd1, 1'b0);
        drain();

        // Hold 0 followed by release of the same pad.
        push(6'd0, 1'b0, 8'd0, 1'b0);
        push(6'd0, 1'b0, 8'd0, 1'b1);
        drain();
        chk("release_pad0", 64'(io_in_o[0]), 64'd1);

        // Contention: drive pads 7 and 2, then enable both outputs at once.
        push(6'd7, 1'b0, 8'd0, 1'b0);
        push(6'd2, 1'b1, 8'd0, 1'b0);
        drain();
        io_oe_i  = (48'd1 << 7) | (48'd1 << 2);
        pulses   = 0;
        seen_pad = 6'd63;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (contention_o) begin
                pulses++;
                seen_pad = contention_pad_o;
            end
        end
        chk("contention_pulses", 64'(pulses), 64'd1);
        chk("contention_lowest", 64'(seen_pad), 64'd2);
        io_oe_i = '0;
        tick();
        tick();
        io_oe_i = 48'd1 << 7;
        for (int i = 0; i < 4; i++) tick();
        io_oe_i = '0;

        // Bad index, then reset while in HOLD.
        push(6'd50, 1'b0, 8'd20, 1'b0);
        push(6'd5, 1'b0, 8'd1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("bad_idx_set", 64'(bad_idx_o), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_io_in", 64'(io_in_o), 64'hFFFF_FFFF_FFFF);
        chk("midreset_bad", 64'(bad_idx_o), 64'd0);
        chk("midreset_busy", 64'(busy_o), 64'd0);
        tick();

`ifdef CVMCU_IO_PAD_DRVR_LOOPBACK_EN
        // Loopback: undriven pad 9 with its output enabled follows io_out_i one cycle late.
        io_oe_i = 48'd1 << 9;
        for (int i = 0; i < 6; i++) begin
            logic prev;
            io_out_i[9] = (i % 2 == 0);
            prev        = io_out_i[9];
            tick();
            chk("loopback_pad9", 64'(io_in_o[9]), 64'(prev));
        end
        io_oe_i  = '0;
        io_out_i = '0;
        tick();
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            reset         = ($urandom_range(0, 149) == 0);
            cmd_valid_i   = $urandom_range(0, 2) == 0;
            cmd_pad_i     = 6'($urandom_range(0, 51));
            cmd_value_i   = 1'($urandom);
            cmd_hold_i    = 8'($urandom_range(0, 4));
            cmd_release_i = ($urandom_range(0, 3) == 0);
            io_out_i      = {16'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 0) begin
                io_oe_i = '0;
            end else begin
                io_oe_i = {16'($urandom), 32'($urandom)} & {16'($urandom), 32'($urandom)}
                        & {16'($urandom), 32'($urandom)} & {16'($urandom), 32'($urandom)};
            end
            tick();
        end
        reset       = 1'b0;
        cmd_valid_i = 1'b0;
        io_oe_i     = '0;
        drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
